reg_file_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single port of register_file (write_en, addr_1, data_in, data_out)

---
 rtl/reg_file_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_file_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin arbiter sharing the single port of register_file
// among NUM_REQ requesters. A grant in cycle T drives the RF port from registers
// in T+1, and read data returns with a one-hot rsp_valid strobe in T+2.
// Optional feature: define RF_ARB_LOCK_EN to add req_lock[NUM_REQ], which lets one
// requester hold the port exclusively for read-modify-write sequences.
module reg_file_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_data_in,
    input  logic [DATA_W-1:0]         rf_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             gnt_any;
    logic             lock_hold;

    logic             rd_vld_p1;
    logic [IDX_W-1:0] rd_id_p1;

`ifdef RF_ARB_LOCK_EN
    logic             lock_active;
    logic [IDX_W-1:0] lock_owner;
`endif

    // Arbitration: first requester at or after rr_ptr (wrapping) wins; a held lock overrides the scan
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef RF_ARB_LOCK_EN
        if (lock_active) begin
            gnt_any = req[lock_owner];
            gnt_idx = lock_owner;
        end
`endif
        if (reset) begin
            gnt_any = 1'b0;
        end
    end

    // One-hot grant vector from the winning index
    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign nxt_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef RF_ARB_LOCK_EN
    // A locked grant keeps the pointer parked so the owner's sequence stays atomic
    assign lock_hold = req_lock[gnt_idx];

    // Lock ownership: set by a grant with req_lock high, released by the owner's unlocked grant
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (gnt_any) begin
            lock_active <= req_lock[gnt_idx];
            lock_owner  <= gnt_idx;
        end
    end
`else
    assign lock_hold = 1'b0;
`endif

    // Round-robin pointer moves past the granted requester; holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (gnt_any && !lock_hold) begin
            rr_ptr <= nxt_ptr;
        end
    end

    // Issue stage (T+1): drive the RF port from the granted request; write strobe lasts one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_en <= 1'b0;
            rf_addr     <= '0;
            rf_data_in  <= '0;
            rd_vld_p1   <= 1'b0;
            rd_id_p1    <= '0;
        end else begin
            rf_write_en <= gnt_any && req_we[gnt_idx];
            rd_vld_p1   <= gnt_any && !req_we[gnt_idx];
            if (gnt_any) begin
                rf_addr    <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                rf_data_in <= req_we[gnt_idx] ? req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
                rd_id_p1   <= gnt_idx;
            end
        end
    end

    // Return stage (T+2): capture combinational RF read data and strobe the owning requester
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (rd_vld_p1) begin
                rsp_valid[rd_id_p1] <= 1'b1;
                rsp_data            <= rf_data_out;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Testbench for reg_file_arbiter: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a transaction-level model.
module tb_reg_file_arbiter;

    localparam int NR = 4;
    localparam int AW = 2;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rf_write_en;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data_in;
    logic [DW-1:0]   rf_data_out;
`ifdef RF_ARB_LOCK_EN
    logic [NR-1:0]   req_lock = '0;
`endif

    reg_file_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef RF_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rf_write_en(rf_write_en),
        .rf_addr    (rf_addr),
        .rf_data_in (rf_data_in),
        .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file stand-in: combinational read, write at the clock edge
    logic [DW-1:0] rf_mem [NR] = '{default: '0};
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_addr] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_addr];

    int checks = 0;
    int failures = 0;

    // Transaction-level model state
    int            m_rr = 0;
    logic [DW-1:0] m_shadow [NR] = '{default: '0};
    logic          e_ok = 1'b0;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [NR-1:0] e_rv;
    logic [DW-1:0] e_rd;
    logic          p_vld = 1'b0;
    int            p_id = 0;
    logic [DW-1:0] p_data;

    // Values seen at the most recent sample point
    logic [NR-1:0] obs_gnt;
    logic [NR-1:0] obs_rv;
    logic [DW-1:0] obs_rd;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_din;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = 1'b1;
        req_we[i]          = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: sample at the falling edge, compare against the model, advance the model, then
    // return just after the rising edge so the caller can drive the next inputs.
    task automatic step();
        logic [NR-1:0] exp_g;
        int            gi;
        logic          found;
        @(negedge clk);
        obs_gnt  = gnt;
        obs_rv   = rsp_valid;
        obs_rd   = rsp_data;
        obs_we   = rf_write_en;
        obs_addr = rf_addr;
        obs_din  = rf_data_in;

        exp_g = '0;
        gi    = 0;
        found = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NR; k++) begin
                if (!found && req[(m_rr + k) % NR]) begin
                    found = 1'b1;
                    gi    = (m_rr + k) % NR;
                end
            end
        end
        if (found) exp_g[gi] = 1'b1;

        check("gnt", {60'd0, obs_gnt}, {60'd0, exp_g});
        if (e_ok) begin
            check("rf_write_en", {63'd0, obs_we}, {63'd0, e_we});
            check("rf_addr", {62'd0, obs_addr}, {62'd0, e_addr});
            check("rf_data_in", obs_din, e_din);
            check("rsp_valid", {60'd0, obs_rv}, {60'd0, e_rv});
            if (e_rv != '0) check("rsp_data", obs_rd, e_rd);
        end

        if (reset) begin
            m_rr   = 0;
            e_we   = 1'b0;
            e_addr = '0;
            e_din  = '0;
            e_rv   = '0;
            e_rd   = '0;
            p_vld  = 1'b0;
            e_ok   = 1'b1;
        end else begin
            e_rv = '0;
            if (p_vld) begin
                e_rv[p_id] = 1'b1;
                e_rd       = p_data;
            end
            p_vld = 1'b0;
            if (found) begin
                e_we   = req_we[gi];
                e_addr = req_addr[gi*AW +: AW];
                if (req_we[gi]) begin
                    e_din = req_wdata[gi*DW +: DW];
                    m_shadow[e_addr] = e_din;
                end else begin
                    e_din  = '0;
                    p_vld  = 1'b1;
                    p_id   = gi;
                    p_data = m_shadow[e_addr];
                end
                m_rr = (gi + 1) % NR;
            end else begin
                e_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_one();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int seq [8];
        seq = '{2, 3, 0, 1, 2, 3, 0, 1};
        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset for two cycles with no requests: everything quiet
        step();
        step();
        reset = 1'b0;
        step();
        check("t1_gnt", {60'd0, obs_gnt}, 64'd0);
        check("t1_we", {63'd0, obs_we}, 64'd0);
        check("t1_rv", {60'd0, obs_rv}, 64'd0);
        check("t1_rd", obs_rd, 64'd0);
        check("t1_din", obs_din, 64'd0);

        // Write 15 to addr 0 then read it back
        set_req(0, 1'b1, 2'd0, 64'd15);
        step();
        check("t2_gnt_w", {60'd0, obs_gnt}, 64'b0001);
        set_req(0, 1'b0, 2'd0, 64'd0);
        step();
        check("t2_gnt_r", {60'd0, obs_gnt}, 64'b0001);
        check("t2_we_pulse", {63'd0, obs_we}, 64'd1);
        check("t2_din", obs_din, 64'd15);
        req = '0;
        step();
        check("t2_we_off", {63'd0, obs_we}, 64'd0);
        step();
        check("t2_rv", {60'd0, obs_rv}, 64'b0001);
        check("t2_rd", obs_rd, 64'd15);

        // All four write at once, then all four read back
        reset_one();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i), 64'(50 + 5 * i));
        for (int k = 0; k < NR; k++) begin
            step();
            check("t3_wgnt", {60'd0, obs_gnt}, 64'(1 << k));
            req[k] = 1'b0;
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), 64'd0);
        for (int k = 0; k < NR + 2; k++) begin
            step();
            if (k < NR) begin
                check("t3_rgnt", {60'd0, obs_gnt}, 64'(1 << k));
                req[k] = 1'b0;
            end
            if (k >= 2) begin
                check("t3_rv", {60'd0, obs_rv}, 64'(1 << (k - 2)));
                check("t3_rd", obs_rd, 64'(50 + 5 * (k - 2)));
            end
        end

        // Rotation from rr_ptr=2 with all requests held
        reset_one();
        set_req(1, 1'b0, 2'd1, 64'd0);
        step();
        check("t4_pre", {60'd0, obs_gnt}, 64'b0010);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4_rot", {60'd0, obs_gnt}, 64'(1 << seq[k]));
        end
        req = '0;
        step();
        step();

        // Reset right after a read grant to requester 1 discards the response
        reset_one();
        set_req(1, 1'b0, 2'd1, 64'd0);
        step();
        check("t5_gnt", {60'd0, obs_gnt}, 64'b0010);
        req   = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t5_rv", {60'd0, obs_rv}, 64'd0);
        check("t5_we", {63'd0, obs_we}, 64'd0);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), 64'd0);
        step();
        check("t5_rrptr", {60'd0, obs_gnt}, 64'b0001);
        req = '0;
        step();
        obs_gnt = '0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (obs_gnt[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    req_we[i] = $urandom_range(0, 1) == 1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, NR - 1));
                    req_wdata[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        req   = '0;
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
